// File: rtl/vga_frame_reader.sv
// VGA timing generator that pulls RGB565 pixels from the SDRAM read FIFO
// and drives the FIFO controller's read window, frame-load pulse and address range.
module vga_frame_reader #(
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          H_DISP    = 640,
  parameter int          H_FRONT   = 16,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter int          V_DISP    = 480,
  parameter int          V_FRONT   = 10,
  parameter int          PRE_LINES = 1,
  parameter logic [22:0] RD_BASE   = 23'd0
) (
  input  logic        clk_read,
  input  logic        rst,
  input  logic        display_en,
  input  logic [15:0] rdf_dout,
  input  logic        rdf_empty,
  output logic        rdf_rdreq,
  output logic        data_valid,
  output logic        rd_load,
  output logic [22:0] rd_addr,
  output logic [22:0] rd_max_addr,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        underflow
);

  localparam logic [11:0] H_TOTAL = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT);
  localparam logic [11:0] V_TOTAL = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT);
  localparam logic [11:0] H_START = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] V_START = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] H_END   = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] V_END   = 12'(V_SYNC + V_BACK + V_DISP);
  localparam logic [11:0] V_DV_LO = 12'(V_SYNC + V_BACK - PRE_LINES);
  localparam logic [11:0] H_SW    = 12'(H_SYNC);
  localparam logic [11:0] V_SW    = 12'(V_SYNC);
  localparam logic [22:0] MAX_ADR = 23'(int'(RD_BASE) + H_DISP * V_DISP);

  logic [11:0] h_cnt, v_cnt;
  logic        en_lat, en_lat_d1;
  logic        h_act, v_act, frame_start;
  logic        hs_d1, vs_d1;
  // de pipeline: [0] = stage 1, [1] = pin
  logic [1:0]  vld_pipe;

  always_comb begin
    h_act       = (h_cnt >= H_START) && (h_cnt < H_END);
    v_act       = (v_cnt >= V_START) && (v_cnt < V_END);
    frame_start = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  end

  assign rdf_rdreq   = h_act & v_act & en_lat;
  assign vga_de      = vld_pipe[1];
  assign rd_addr     = RD_BASE;
  assign rd_max_addr = MAX_ADR;

  always_ff @(posedge clk_read) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_TOTAL - 12'd1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_TOTAL - 12'd1) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_ff @(posedge clk_read) begin
    if (rst) begin
      en_lat     <= 1'b0;
      en_lat_d1  <= 1'b0;
      rd_load    <= 1'b0;
      data_valid <= 1'b0;
      underflow  <= 1'b0;
      hs_d1      <= 1'b1;
      vs_d1      <= 1'b1;
      vld_pipe   <= '0;
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      vga_rgb    <= '0;
    end else begin
      // enable is frozen for the whole frame so a mid-frame change cannot tear it
      if (frame_start) en_lat <= display_en;
      rd_load <= frame_start & display_en;
      // the read window only moves on line boundaries; opening PRE_LINES early lets the FIFO prefill
      if (h_cnt == 12'd0)
        data_valid <= en_lat & (v_cnt >= V_DV_LO) & (v_cnt < V_END);
      if (rdf_rdreq & rdf_empty) underflow <= 1'b1;
      hs_d1     <= ~(h_cnt < H_SW);
      vs_d1     <= ~(v_cnt < V_SW);
      en_lat_d1 <= en_lat;
      vld_pipe  <= {vld_pipe[0], h_act & v_act};
      vga_hs    <= hs_d1;
      vga_vs    <= vs_d1;
      // FIFO word arrives the cycle after rdreq, i.e. alongside the stage-1 de bit
      vga_rgb   <= (vld_pipe[0] & en_lat_d1) ? rdf_dout : 16'h0000;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a shrunken raster; expectations come
// from raster arithmetic on the cycle position since reset.
module tb_vga_frame_reader;

  localparam int HSY = 4, HBK = 3, HD = 8, HFR = 2;
  localparam int VSY = 2, VBK = 3, VD = 4, VFR = 2;
  localparam int PRE = 2;
  localparam logic [22:0] RDB = 23'h001000;
  localparam int HT = HSY + HBK + HD + HFR;
  localparam int VT = VSY + VBK + VD + VFR;
  localparam int FT = HT * VT;
  localparam int HS = HSY + HBK;
  localparam int VS = VSY + VBK;

  logic        clk_read = 1'b0;
  logic        rst, display_en, rdf_empty;
  logic [15:0] rdf_dout;
  logic        rdf_rdreq, data_valid, rd_load, vga_hs, vga_vs, vga_de, underflow;
  logic [22:0] rd_addr, rd_max_addr;
  logic [15:0] vga_rgb;

  vga_frame_reader #(
    .H_SYNC(HSY), .H_BACK(HBK), .H_DISP(HD), .H_FRONT(HFR),
    .V_SYNC(VSY), .V_BACK(VBK), .V_DISP(VD), .V_FRONT(VFR),
    .PRE_LINES(PRE), .RD_BASE(RDB)
  ) dut (
    .clk_read(clk_read), .rst(rst), .display_en(display_en),
    .rdf_dout(rdf_dout), .rdf_empty(rdf_empty), .rdf_rdreq(rdf_rdreq),
    .data_valid(data_valid), .rd_load(rd_load), .rd_addr(rd_addr),
    .rd_max_addr(rd_max_addr), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_de(vga_de), .vga_rgb(vga_rgb), .underflow(underflow)
  );

  always #5 clk_read = ~clk_read;

  int          n_tests = 0, n_fail = 0;
  int          pos = 0, cur_h = 0, cur_v = 0;
  int          mreq = 0, fctr = 0;
  bit          armed = 0, uf_m = 0, req_s = 0;
  bit          frame_en [0:255];
  logic [15:0] exp_q [$];

  function automatic logic [15:0] word(int k);
    return 16'(k * 263 + 165);
  endfunction
  function automatic int h_of(int p); return p % HT; endfunction
  function automatic int v_of(int p); return (p / HT) % VT; endfunction
  function automatic bit act(int p);
    return h_of(p) >= HS && h_of(p) < HS + HD && v_of(p) >= VS && v_of(p) < VS + VD;
  endfunction
  // enable seen by the design during cycle p: latched at the previous frame-start edge
  function automatic bit en_at(int p);
    if (p == 0) return 1'b0;
    return frame_en[(p - 1) / FT];
  endfunction
  function automatic bit rdreq_at(int p); return act(p) && en_at(p); endfunction
  function automatic bit load_at(int p);
    return p >= 1 && ((p - 1) % FT == 0) && frame_en[(p - 1) / FT];
  endfunction
  function automatic bit dv_at(int p);
    int q;
    if (p == 0) return 1'b0;
    q = ((p - 1) / HT) * HT;
    return en_at(q) && v_of(q) >= VS - PRE && v_of(q) < VS + VD;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s pos=%0d h=%0d v=%0d got=%h want=%h", nm, pos, cur_h, cur_v, got, want);
    end
  endtask

  // reference model position and sticky underflow
  always @(posedge clk_read) begin
    if (rst) begin
      pos = 0;
      uf_m = 0;
      exp_q.delete();
    end else begin
      if (pos % FT == 0) frame_en[pos / FT] = display_en;
      if (rdreq_at(pos) && rdf_empty) uf_m = 1;
      pos++;
    end
    armed = 1;
    cur_h = h_of(pos);
    cur_v = v_of(pos);
  end

  // FIFO model: data follows a request by one cycle, junk otherwise
  always @(negedge clk_read) req_s = rdf_rdreq;
  always @(posedge clk_read) begin
    #1;
    if (req_s) begin
      rdf_dout = word(fctr);
      fctr++;
    end else begin
      rdf_dout = 16'($urandom);
    end
  end

  // scoreboard producer: one entry per active-region pixel issued
  always @(negedge clk_read) begin
    if (armed && act(pos)) begin
      if (en_at(pos)) begin
        exp_q.push_back(word(mreq));
        mreq++;
      end else begin
        exp_q.push_back(16'h0000);
      end
    end
  end

  // pixel monitor
  always @(negedge clk_read) begin
    if (armed) begin
      if (vga_de === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL vga_rgb pos=%0d got=%h want=<no pixel pending>", pos, vga_rgb);
        end else begin
          chk("vga_rgb", 32'(vga_rgb), 32'(exp_q.pop_front()));
        end
      end else begin
        chk("vga_rgb_blank", 32'(vga_rgb), 32'h0);
      end
    end
  end

  // control and timing checks
  always @(negedge clk_read) begin
    if (armed) begin
      chk("rdf_rdreq", 32'(rdf_rdreq), 32'(rdreq_at(pos)));
      chk("data_valid", 32'(data_valid), 32'(dv_at(pos)));
      chk("rd_load", 32'(rd_load), 32'(load_at(pos)));
      chk("underflow", 32'(underflow), 32'(uf_m));
      if (pos < 2) begin
        chk("vga_hs", 32'(vga_hs), 32'h1);
        chk("vga_vs", 32'(vga_vs), 32'h1);
        chk("vga_de", 32'(vga_de), 32'h0);
      end else begin
        chk("vga_hs", 32'(vga_hs), 32'(h_of(pos - 2) >= HSY));
        chk("vga_vs", 32'(vga_vs), 32'(v_of(pos - 2) >= VSY));
        chk("vga_de", 32'(vga_de), 32'(act(pos - 2)));
      end
    end
  end

  task automatic wait_pos(int h, int v);
    int k = 0;
    do begin
      @(negedge clk_read);
      k++;
    end while (!(cur_h == h && cur_v == v) && k < 4 * FT);
    if (k >= 4 * FT) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_pos got=timeout want=h%0d_v%0d", h, v);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    display_en = 1'b0;
    rdf_empty = 1'b0;
    rdf_dout = 16'h0;
    repeat (3) @(negedge clk_read);
    rst = 1'b0;
    chk("rd_addr", 32'(rd_addr), 32'(RDB));
    chk("rd_max_addr", 32'(rd_max_addr), int'(RDB) + HD * VD);

    // disabled: timing only
    repeat (FT + FT / 2) @(negedge clk_read);
    wait_pos(0, VT - 1);
    display_en = 1'b1;
    repeat (3 * FT) @(negedge clk_read);

    // drop enable mid-frame: current frame completes, next one is dark
    wait_pos(3, VS + 1);
    display_en = 1'b0;
    repeat (2 * FT) @(negedge clk_read);

    // random enable toggling
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(20, 2 * FT)) @(negedge clk_read);
      display_en = 1'($urandom_range(0, 1));
    end
    display_en = 1'b1;
    repeat (2 * FT) @(negedge clk_read);

    // one-cycle empty during an active, enabled pixel
    wait_pos(HS + 2, VS + 1);
    rdf_empty = 1'b1;
    @(negedge clk_read);
    rdf_empty = 1'b0;
    repeat (2 * FT) @(negedge clk_read);

    // reset mid-frame, then restart with enable held high
    wait_pos(HS + 1, VS + 1);
    rst = 1'b1;
    @(negedge clk_read);
    rst = 1'b0;
    repeat (2 * FT) @(negedge clk_read);

    wait_pos(1, 0);
    chk("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
